// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: byte-command bridge from a UART rx/tx pair to a sync memory.
// Commands: 'W' addr data = write, 'R' addr = read (one reply byte),
//   any other opcode is answered with '?'.
// Optional macro UART_MEM_BRIDGE_BURST_EN adds 'B' addr len, which reads
//   len+1 bytes starting at addr, wrapping the address.
// Ports: clk, reset (async, active-high);
//   rx_data/rx_valid   received bytes, one-cycle strobe
//   tx_data/tx_start   reply byte and one-cycle request; tx_busy from transmitter
//   mem_ce/mem_wre/mem_ad/mem_din/mem_dout  memory port
//   busy               FSM not idle
//   overrun            pulse when a byte arrives while not receiving
module uart_mem_bridge #(
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 2,
  parameter int TIMEOUT  = 27000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              overrun
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [1:0] LAT = 2'(READ_LAT);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    GET_DATA,
    WRITE,
    READ_WAIT,
    SEND,
    WAIT_TX
  } state_t;

  typedef enum logic [1:0] {
    OP_WR,
    OP_RD,
    OP_BURST
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [1:0]        lat_q, lat_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              first_q, first_d;
  logic              overrun_q, overrun_d;
`ifdef UART_MEM_BRIDGE_BURST_EN
  logic [7:0]        burst_q, burst_d;
`endif

  logic rx_state;

  assign rx_state = (state_q == GET_ADDR) ||
                    (state_q == GET_LEN) ||
                    (state_q == GET_DATA);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_data_d = tx_data_q;
    lat_d     = lat_q;
    to_d      = to_q;
    first_d   = 1'b0;
    overrun_d = 1'b0;
`ifdef UART_MEM_BRIDGE_BURST_EN
    burst_d   = burst_q;
`endif
    tx_start  = 1'b0;
    mem_ce    = 1'b0;
    mem_wre   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          to_d = '0;
          if (rx_data == 8'h57) begin
            op_d    = OP_WR;
            state_d = GET_ADDR;
          end else if (rx_data == 8'h52) begin
            op_d    = OP_RD;
            state_d = GET_ADDR;
`ifdef UART_MEM_BRIDGE_BURST_EN
          end else if (rx_data == 8'h42) begin
            op_d    = OP_BURST;
            state_d = GET_ADDR;
`endif
          end else begin
            tx_data_d = 8'h3F;
            state_d   = SEND;
          end
        end
      end

      GET_ADDR: begin
        if (rx_valid) begin
          addr_d = rx_data[ADDR_W-1:0];
          to_d   = '0;
          case (op_q)
            OP_WR: state_d = GET_DATA;
`ifdef UART_MEM_BRIDGE_BURST_EN
            OP_BURST: state_d = GET_LEN;
`endif
            default: begin
              lat_d   = '0;
              state_d = READ_WAIT;
            end
          endcase
        end
      end

`ifdef UART_MEM_BRIDGE_BURST_EN
      GET_LEN: begin
        if (rx_valid) begin
          burst_d = rx_data;
          to_d    = '0;
          lat_d   = '0;
          state_d = READ_WAIT;
        end
      end
`endif

      GET_DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          to_d    = '0;
          state_d = WRITE;
        end
      end

      WRITE: begin
        mem_ce  = 1'b1;
        mem_wre = 1'b1;
        state_d = IDLE;
      end

      // lat_q == 0 is the access cycle; data is taken READ_LAT cycles later
      READ_WAIT: begin
        if (lat_q == 2'd0) begin
          mem_ce = 1'b1;
        end
        if (lat_q == LAT) begin
          tx_data_d = mem_dout;
          state_d   = SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          first_d  = 1'b1;
          state_d  = WAIT_TX;
        end
      end

      // transmitter may not raise busy until a cycle after tx_start
      WAIT_TX: begin
        if (!first_q && !tx_busy) begin
          state_d = IDLE;
`ifdef UART_MEM_BRIDGE_BURST_EN
          if (burst_q != 8'd0) begin
            burst_d = burst_q - 1'b1;
            addr_d  = addr_q + 1'b1;
            lat_d   = '0;
            state_d = READ_WAIT;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    // a byte arriving on the expiry cycle wins over the timeout
    if (rx_state && !rx_valid) begin
      if (to_q == TO_LAST) begin
        to_d    = '0;
        state_d = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    if (rx_valid && !rx_state && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_WR;
      addr_q    <= '0;
      data_q    <= '0;
      tx_data_q <= '0;
      lat_q     <= '0;
      to_q      <= '0;
      first_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_MEM_BRIDGE_BURST_EN
      burst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_data_q <= tx_data_d;
      lat_q     <= lat_d;
      to_q      <= to_d;
      first_q   <= first_d;
      overrun_q <= overrun_d;
`ifdef UART_MEM_BRIDGE_BURST_EN
      burst_q   <= burst_d;
`endif
    end
  end

  assign tx_data = tx_data_q;
  assign mem_ad  = addr_q;
  assign mem_din = data_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: scoreboard bench for uart_mem_bridge.
// Stimulus pushes expected tx bytes, writes and read addresses; monitors pop.
module tb_uart_mem_bridge;
  localparam int AW = 4;
  localparam int RL = 2;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          mem_ce;
  logic          mem_wre;
  logic [AW-1:0] mem_ad;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic          busy;
  logic          overrun;

  logic busy_m = 1'b0;
  logic busy_f = 1'b0;

  int total = 0;
  int bad   = 0;
  int tx_cnt = 0;
  int ce_cnt = 0;
  int ovr_cnt = 0;

  logic [7:0]    exp_tx[$];
  logic [11:0]   exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  logic [7:0]    e8;
  logic [11:0]   e12;
  logic [AW-1:0] e4;

  logic [7:0] mem [0:15];
  logic       v_pipe [1:RL];
  logic [7:0] d_pipe [1:RL];

  always #5 clk = ~clk;
  assign tx_busy = busy_m | busy_f;

  uart_mem_bridge #(
    .ADDR_W(AW),
    .READ_LAT(RL),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .mem_ce(mem_ce),
    .mem_wre(mem_wre),
    .mem_ad(mem_ad),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .busy(busy),
    .overrun(overrun)
  );

  // memory model: read data is valid only in the cycle RL after access
  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 8'(16 + i);
    for (int i = 1; i <= RL; i++) begin
      v_pipe[i] <= 1'b0;
      d_pipe[i] <= 8'h00;
    end
  end

  always @(posedge clk) begin
    v_pipe[1] <= mem_ce & ~mem_wre;
    d_pipe[1] <= mem[mem_ad];
    for (int i = 2; i <= RL; i++) begin
      v_pipe[i] <= v_pipe[i-1];
      d_pipe[i] <= d_pipe[i-1];
    end
    if (mem_ce & mem_wre) mem[mem_ad] <= mem_din;
  end

  assign mem_dout = v_pipe[RL] ? d_pipe[RL] : 8'hEE;

  // transmitter model: busy for 8 cycles starting the cycle after tx_start
  initial forever begin
    @(negedge clk);
    if (tx_start && !reset) begin
      @(posedge clk);
      #1 busy_m = 1'b1;
      repeat (8) @(posedge clk);
      #1 busy_m = 1'b0;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        tx_cnt++;
        total++;
        if (exp_tx.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected got=%h want=none", tx_data);
        end else begin
          e8 = exp_tx.pop_front();
          if (tx_data !== e8) begin
            bad++;
            $display("FAIL tx_byte got=%h want=%h", tx_data, e8);
          end
        end
      end
      if (mem_ce) ce_cnt++;
      if (mem_ce && mem_wre) begin
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected got=%h want=none", {mem_ad, mem_din});
        end else begin
          e12 = exp_wr.pop_front();
          if ({mem_ad, mem_din} !== e12) begin
            bad++;
            $display("FAIL wr_access got=%h want=%h", {mem_ad, mem_din}, e12);
          end
        end
      end
      if (mem_ce && !mem_wre) begin
        total++;
        if (exp_rd.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected got=%h want=none", mem_ad);
        end else begin
          e4 = exp_rd.pop_front();
          if (mem_ad !== e4) begin
            bad++;
            $display("FAIL rd_addr got=%h want=%h", mem_ad, e4);
          end
        end
      end
      if (overrun) ovr_cnt++;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_mem_wre", 32'(mem_wre), 32'd0);
    chk("rst_mem_ad", 32'(mem_ad), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int ovr0;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_reset();

    // write then read back
    exp_wr.push_back({4'h3, 8'hA5});
    send_gap(8'h57); send_gap(8'h03); send_byte(8'hA5);
    wait_idle();
    exp_rd.push_back(4'h3); exp_tx.push_back(8'hA5);
    send_gap(8'h52); send_byte(8'h03);
    wait_idle();

    // address truncation, unknown opcode
    exp_rd.push_back(4'h3); exp_tx.push_back(8'hA5);
    send_gap(8'h52); send_byte(8'h13);
    wait_idle();
    exp_tx.push_back(8'h3F);
    send_byte(8'h7A);
    wait_idle();

    // second location, truncated on write
    exp_wr.push_back({4'hA, 8'h5C});
    send_gap(8'h57); send_gap(8'h1A); send_byte(8'h5C);
    wait_idle();
    exp_rd.push_back(4'hA); exp_tx.push_back(8'h5C);
    send_gap(8'h52); send_byte(8'h0A);
    wait_idle();

    // byte on the expiry cycle is still accepted
    exp_wr.push_back({4'h5, 8'h66});
    send_gap(8'h57); send_byte(8'h05);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h66);
    wait_idle();
    exp_rd.push_back(4'h5); exp_tx.push_back(8'h66);
    send_gap(8'h52); send_byte(8'h05);
    wait_idle();

    // timeout drops the command
    snap = ce_cnt;
    send_gap(8'h57); send_byte(8'h09);
    repeat (TO - 10) @(posedge clk);
    #1 chk("to_still_busy", 32'(busy), 32'd1);
    repeat (20) @(posedge clk);
    #1 chk("to_idle", 32'(busy), 32'd0);
    chk("to_no_access", 32'(ce_cnt - snap), 32'd0);
    exp_rd.push_back(4'h9); exp_tx.push_back(8'h19);
    send_gap(8'h52); send_byte(8'h09);
    wait_idle();

    // held tx_busy, overrun during SEND
    busy_f = 1'b1;
    snap = tx_cnt;
    ovr0 = ovr_cnt;
    exp_rd.push_back(4'h3); exp_tx.push_back(8'hA5);
    send_gap(8'h52); send_byte(8'h03);
    repeat (5) @(posedge clk);
    send_byte(8'h11);
    repeat (45) @(posedge clk);
    #1 chk("busy_hold_no_tx", 32'(tx_cnt - snap), 32'd0);
    chk("busy_hold_state", 32'(busy), 32'd1);
    busy_f = 1'b0;
    wait_idle();
    chk("busy_release_tx", 32'(tx_cnt - snap), 32'd1);
    chk("overrun_pulse", 32'(ovr_cnt - ovr0), 32'd1);

    // reset mid-command cancels the pending write
    send_gap(8'h57); send_byte(8'h07);
    do_reset();
    exp_rd.push_back(4'h7); exp_tx.push_back(8'h17);
    send_gap(8'h52); send_byte(8'h07);
    wait_idle();

`ifdef UART_MEM_BRIDGE_BURST_EN
    snap = tx_cnt;
    exp_rd.push_back(4'hE); exp_tx.push_back(8'h1E);
    exp_rd.push_back(4'hF); exp_tx.push_back(8'h1F);
    send_gap(8'h42); send_gap(8'h0E); send_byte(8'h03);
    begin
      int n = 0;
      while ((tx_cnt - snap) < 2 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    chk("burst_two_bytes", 32'(tx_cnt - snap), 32'd2);
    do_reset();
    repeat (200) @(posedge clk);
    #1 chk("burst_cut_by_reset", 32'(tx_cnt - snap), 32'd2);
`else
    exp_tx.push_back(8'h3F);
    send_byte(8'h42);
    wait_idle();
`endif

    chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("overrun_total", 32'(ovr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
